// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: packs N-bit beats into bytes, holds each frame until the checksum
// stage rules on it, then streams committed frames out with valid/ready/last.
module rx_frame_buffer #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned MAXF  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] axiid,
  input  logic         axiiv,
  input  logic         rx_done,
  input  logic         rx_kill,
  output logic [7:0]   axiod,
  output logic         axiov,
  output logic         axiol,
  input  logic         axiir,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned BPB = 8 / N;
  localparam int unsigned CW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW  = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int unsigned LD  = 2 ** LW;

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);
  localparam logic [AW:0] PtrTwo = (AW + 1)'(2);
  localparam logic [LW:0] LfOne  = (LW + 1)'(1);

  localparam logic [1:0] WIdle = 2'd0;
  localparam logic [1:0] WRecv = 2'd1;
  localparam logic [1:0] WWait = 2'd2;
  localparam logic [1:0] WDrop = 2'd3;

  localparam logic [1:0] RIdle = 2'd0;
  localparam logic [1:0] RLoad = 2'd1;
  localparam logic [1:0] RSend = 2'd2;

  logic [7:0]    mem    [DEPTH];
  logic [AW:0]   lf_mem [LD];

  // Write side
  logic [1:0]    wstate_q, wstate_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   wr_base_q, wr_base_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [7:0]    byte_next;
  logic [AW:0]   frame_len;
  logic          beat_last, buf_full, lf_full, lf_empty;
  logic          accept, rollback, commit;
  logic          mem_we, lf_push, drop_inc;

  // Read side
  logic [1:0]    rstate_q, rstate_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   lf_head;
  logic [AW-1:0] rd_addr;
  logic          rd_en, lf_pop, frame_sent;
  logic [7:0]    axiod_q;
  logic          axiov_q, axiov_d;
  logic          axiol_q, axiol_d;

  logic [LW:0]   lf_wr_q, lf_rd_q;
  logic [LW:0]   frames_q, frames_d;
  logic [15:0]   drop_cnt_q;

  assign byte_next = 8'({shreg_q, axiid});
  assign beat_last = (beat_q == CW'(BPB - 1));
  assign frame_len = wr_ptr_q - wr_base_q;
  assign buf_full  = ((wr_ptr_q - rd_ptr_q) == (AW + 1)'(DEPTH));
  // A frame holds its slot until its last byte has left, so a stalled frame counts.
  assign lf_full   = (frames_q == (LW + 1)'(MAXF));
  assign lf_empty  = (lf_wr_q == lf_rd_q);
  assign lf_head   = lf_mem[lf_rd_q[LW-1:0]];

  always_comb begin
    wstate_d  = wstate_q;
    wr_ptr_d  = wr_ptr_q;
    wr_base_d = wr_base_q;
    shreg_d   = shreg_q;
    beat_d    = beat_q;
    accept    = 1'b0;
    rollback  = 1'b0;
    commit    = 1'b0;
    mem_we    = 1'b0;
    lf_push   = 1'b0;
    drop_inc  = 1'b0;

    unique case (wstate_q)
      WIdle: begin
        if (axiiv) begin
          if (lf_full) begin
            wstate_d = WDrop;
          end else begin
            wstate_d = WRecv;
            accept   = 1'b1;
          end
        end
      end
      WRecv: begin
        if (rx_kill) begin
          rollback = 1'b1;
        end else if (rx_done) begin
          commit = 1'b1;
        end else if (axiiv) begin
          accept = 1'b1;
        end else begin
          wstate_d = WWait;
          beat_d   = '0;
        end
      end
      WWait: begin
        if (rx_kill) begin
          rollback = 1'b1;
        end else if (rx_done) begin
          commit = 1'b1;
        end
      end
      WDrop: begin
        if (rx_kill || rx_done) begin
          rollback = 1'b1;
        end
      end
      default: wstate_d = WIdle;
    endcase

    if (accept) begin
      shreg_d = byte_next;
      if (!beat_last) begin
        beat_d = beat_q + CW'(1);
      end else begin
        beat_d = '0;
        if (buf_full) begin
          wstate_d = WDrop;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
        end
      end
    end

    if (rollback) begin
      wr_ptr_d = wr_base_q;
      drop_inc = 1'b1;
      wstate_d = WIdle;
      beat_d   = '0;
    end

    // An empty good frame is simply forgotten.
    if (commit) begin
      if (frame_len != '0) begin
        lf_push   = 1'b1;
        wr_base_d = wr_ptr_q;
      end
      wstate_d = WIdle;
      beat_d   = '0;
    end
  end

  always_comb begin
    rstate_d   = rstate_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    axiov_d    = axiov_q;
    axiol_d    = axiol_q;
    lf_pop     = 1'b0;
    frame_sent = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr_q[AW-1:0];

    unique case (rstate_q)
      RIdle: begin
        if (!lf_empty) begin
          lf_pop   = 1'b1;
          rem_d    = lf_head;
          rd_en    = 1'b1;
          axiov_d  = 1'b1;
          axiol_d  = (lf_head == PtrOne);
          rstate_d = RLoad;
        end
      end
      RLoad, RSend: begin
        if (axiir) begin
          rd_ptr_d = rd_ptr_q + PtrOne;
          if (rem_q == PtrOne) begin
            frame_sent = 1'b1;
            axiov_d    = 1'b0;
            axiol_d    = 1'b0;
            rstate_d   = RIdle;
          end else begin
            // Fetch the following byte now so it is on axiod right after this transfer.
            rem_d    = rem_q - PtrOne;
            rd_en    = 1'b1;
            rd_addr  = rd_ptr_d[AW-1:0];
            axiol_d  = (rem_q == PtrTwo);
            rstate_d = RSend;
          end
        end else begin
          rstate_d = RSend;
        end
      end
      default: rstate_d = RIdle;
    endcase
  end

  always_comb begin
    frames_d = frames_q;
    unique case ({lf_push, frame_sent})
      2'b10:   frames_d = frames_q + LfOne;
      2'b01:   frames_d = frames_q - LfOne;
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q   <= WIdle;
      wr_ptr_q   <= '0;
      wr_base_q  <= '0;
      shreg_q    <= '0;
      beat_q     <= '0;
      rstate_q   <= RIdle;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      axiod_q    <= '0;
      axiov_q    <= 1'b0;
      axiol_q    <= 1'b0;
      lf_wr_q    <= '0;
      lf_rd_q    <= '0;
      frames_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_base_q <= wr_base_d;
      shreg_q   <= shreg_d;
      beat_q    <= beat_d;
      rstate_q  <= rstate_d;
      rd_ptr_q  <= rd_ptr_d;
      rem_q     <= rem_d;
      axiov_q   <= axiov_d;
      axiol_q   <= axiol_d;
      frames_q  <= frames_d;
      if (rd_en) begin
        axiod_q <= mem[rd_addr];
      end
      if (lf_push) begin
        lf_wr_q <= lf_wr_q + LfOne;
      end
      if (lf_pop) begin
        lf_rd_q <= lf_rd_q + LfOne;
      end
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= byte_next;
    end
    if (lf_push) begin
      lf_mem[lf_wr_q[LW-1:0]] <= frame_len;
    end
  end

  assign axiod    = axiod_q;
  assign axiov    = axiov_q;
  assign axiol    = axiol_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: drives framed beats, models which frames survive and
// compares the delivered byte stream and last flags against that model.
module tb_rx_frame_buffer;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned MAXF  = 4;
  localparam int unsigned BPB   = 8 / N;

  logic         clk;
  logic         rst;
  logic [N-1:0] axiid;
  logic         axiiv;
  logic         rx_done;
  logic         rx_kill;
  logic [7:0]   axiod;
  logic         axiov;
  logic         axiol;
  logic         axiir;
  logic [15:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] got_q[$];
  bit         got_last_q[$];

  int frames_seen = 0;
  int ov_cycles   = 0;
  int stall_viol  = 0;
  int exp_drop    = 0;
  int rdy_mode    = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;

  rx_frame_buffer #(.N(N), .DEPTH(DEPTH), .MAXF(MAXF)) dut (
    .clk      (clk),
    .rst      (rst),
    .axiid    (axiid),
    .axiiv    (axiiv),
    .rx_done  (rx_done),
    .rx_kill  (rx_kill),
    .axiod    (axiod),
    .axiov    (axiov),
    .axiol    (axiol),
    .axiir    (axiir),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready pattern: 0 = held low, 1 = held high, otherwise random each cycle.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      axiir = 1'b0;
    else if (rdy_mode == 1) axiir = 1'b1;
    else                    axiir = 1'($urandom_range(0, 1));
  end

  // Output monitor: records transfers and watches stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (axiov !== 1'b1 || axiod !== prev_d || axiol !== prev_l)) stall_viol++;
      if (axiov) ov_cycles++;
      if (axiov && axiir) begin
        got_q.push_back(axiod);
        got_last_q.push_back(axiol);
        if (axiol) frames_seen++;
      end
      prev_stall = axiov && !axiir;
      prev_d     = axiod;
      prev_l     = axiol;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic make_frame(input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
  endtask

  // Model: a surviving frame contributes its bytes in order, last flag on its final byte.
  task automatic expect_frame();
    foreach (tx_q[i]) begin
      exp_q.push_back(tx_q[i]);
      exp_last_q.push_back(i == tx_q.size() - 1);
    end
  endtask

  task automatic clear_streams();
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
    exp_last_q.delete();
  endtask

  // ending: 0 = rx_done, 1 = rx_kill, 2 = both in the same cycle
  task automatic send_frame(input int ending);
    foreach (tx_q[i]) begin
      for (int k = 0; k < int'(BPB); k++) begin
        axiiv = 1'b1;
        axiid = tx_q[i][7-k*N -: N];
        tick(1);
      end
    end
    axiiv   = 1'b0;
    axiid   = '0;
    rx_done = (ending == 0 || ending == 2);
    rx_kill = (ending == 1 || ending == 2);
    tick(1);
    rx_done = 1'b0;
    rx_kill = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; axiiv = 1'b0; axiid = '0; rx_done = 1'b0; rx_kill = 1'b0; rdy_mode = 0;
    tick(3);
    checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL reset_axiov: got %b want 0", axiov); end
    checks++; if (axiol !== 1'b0) begin errors++; $display("FAIL reset_axiol: got %b want 0", axiol); end
    checks++; if (axiod !== 8'h00) begin errors++; $display("FAIL reset_axiod: got %h want 00", axiod); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    @(negedge clk);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_pattern();
    rdy_mode = 0;
    clear_streams();
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'hC9);
    expect_frame();
    send_frame(0);
    checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL pat_early: axiov %b want 0", axiov); end
    tick(1);
    checks++; if (axiov !== 1'b1) begin errors++; $display("FAIL pat_latency: axiov %b want 1", axiov); end
    checks++; if (axiod !== 8'hC9) begin errors++; $display("FAIL pat_first: got %h want c9", axiod); end
    checks++; if (axiol !== 1'b0) begin errors++; $display("FAIL pat_first_last: got %b want 0", axiol); end
    tick(3);
    rdy_mode = 1;
    wait_bytes(4, 50);
    tick(8);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL pat_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        errors++;
        $display("FAIL pat_byte[%0d]: got %h/%b want %h/%b", i, got_q[i], got_last_q[i],
                 exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_kill();
    int ov0;
    rdy_mode = 1;
    clear_streams();
    ov0 = ov_cycles;
    make_frame(60);
    send_frame(1);
    exp_drop++;
    tick(10);
    checks++; if (ov_cycles !== ov0) begin errors++; $display("FAIL kill_ov: %0d valid cycles want 0", ov_cycles - ov0); end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL kill_drop: got %0d want %0d", drop_cnt, exp_drop); end
    make_frame(60);
    expect_frame();
    send_frame(0);
    wait_bytes(60, 200);
    tick(8);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL kill_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        errors++;
        $display("FAIL kill_byte[%0d]: got %h/%b want %h/%b", i, got_q[i], got_last_q[i],
                 exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int ov0;
    rdy_mode = 1;
    clear_streams();
    ov0 = ov_cycles;
    make_frame(70);
    send_frame(0);
    exp_drop++;
    tick(10);
    checks++; if (ov_cycles !== ov0) begin errors++; $display("FAIL ovf_ov: %0d valid cycles want 0", ov_cycles - ov0); end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL ovf_drop: got %0d want %0d", drop_cnt, exp_drop); end
    make_frame(10);
    expect_frame();
    send_frame(0);
    wait_bytes(10, 100);
    tick(8);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        errors++;
        $display("FAIL ovf_byte[%0d]: got %h/%b want %h/%b", i, got_q[i], got_last_q[i],
                 exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_maxf();
    int fs0;
    rdy_mode = 0;
    clear_streams();
    tick(2);
    for (int f = 0; f < 5; f++) begin
      make_frame(8);
      if (f < int'(MAXF)) expect_frame();
      send_frame(0);
      tick(2);
    end
    exp_drop++;
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL maxf_drop: got %0d want %0d", drop_cnt, exp_drop); end
    fs0 = frames_seen;
    rdy_mode = 1;
    wait_bytes(32, 300);
    tick(10);
    checks++; if (frames_seen - fs0 !== 4) begin errors++; $display("FAIL maxf_frames: got %0d want 4", frames_seen - fs0); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL maxf_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        errors++;
        $display("FAIL maxf_byte[%0d]: got %h/%b want %h/%b", i, got_q[i], got_last_q[i],
                 exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_done_kill();
    int ov0;
    rdy_mode = 1;
    ov0 = ov_cycles;
    make_frame(6);
    send_frame(2);
    exp_drop++;
    tick(10);
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL both_drop: got %0d want %0d", drop_cnt, exp_drop); end
    // Strobes while idle and a frame with only a partial byte: neither is counted nor sent.
    rx_kill = 1'b1; tick(1); rx_kill = 1'b0;
    rx_done = 1'b1; tick(1); rx_done = 1'b0;
    axiiv = 1'b1; axiid = 2'b11; tick(1);
    axiiv = 1'b0; axiid = '0; rx_done = 1'b1; tick(1); rx_done = 1'b0;
    tick(10);
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL idle_strobe_drop: got %0d want %0d", drop_cnt, exp_drop); end
    checks++; if (ov_cycles !== ov0) begin errors++; $display("FAIL both_ov: %0d valid cycles want 0", ov_cycles - ov0); end
  endtask

  task automatic test_random();
    int committed = 0;
    int fs0;
    int c;
    int r;
    int ending;
    clear_streams();
    fs0 = frames_seen;
    stall_viol = 0;
    rdy_mode = 2;
    for (int f = 0; f < 24; f++) begin
      c = 0;
      while (committed - (frames_seen - fs0) >= int'(MAXF) && c < 500) begin
        tick(1);
        c++;
      end
      checks++;
      if (committed - (frames_seen - fs0) >= int'(MAXF)) begin
        errors++; $display("FAIL rand_drain: %0d frames still queued", committed - (frames_seen - fs0));
      end
      make_frame(int'($urandom_range(1, 12)));
      r = int'($urandom_range(0, 9));
      ending = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
      if (ending == 0) begin
        expect_frame();
        committed++;
      end else begin
        exp_drop++;
      end
      send_frame(ending);
      tick(int'($urandom_range(0, 3)));
    end
    wait_bytes(exp_q.size(), 3000);
    tick(10);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        errors++;
        $display("FAIL rand_byte[%0d]: got %h/%b want %h/%b", i, got_q[i], got_last_q[i],
                 exp_q[i], exp_last_q[i]);
      end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rand_stall: %0d unstable stall cycles want 0", stall_viol); end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d want %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 1;
    clear_streams();
    make_frame(20);
    send_frame(0);
    wait_bytes(5, 50);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL mid_axiov: got %b want 0", axiov); end
    checks++; if (axiol !== 1'b0) begin errors++; $display("FAIL mid_axiol: got %b want 0", axiol); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", drop_cnt); end
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    exp_drop = 0;
    tick(1);
    clear_streams();
    make_frame(10);
    expect_frame();
    send_frame(0);
    wait_bytes(10, 100);
    tick(10);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        errors++;
        $display("FAIL mid_byte[%0d]: got %h/%b want %h/%b", i, got_q[i], got_last_q[i],
                 exp_q[i], exp_last_q[i]);
      end
    end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL mid_drop_after: got %0d want %0d", drop_cnt, exp_drop); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_kill();
    test_overflow();
    test_maxf();
    test_done_kill();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
